// File: rtl/mem_access_stage.sv
// Memory stage behind Execute: ALU passthrough to writeback, or one Local Store quadword
// load/store over a req/ack handshake with timeout abort, then a registered writeback pulse.
module mem_access_stage #(
   parameter int DATA_W    = 128,
   parameter int LS_ADDR_W = 14,
   parameter int REG_W     = 7,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic                 ex_mem_read,
   input  logic                 ex_mem_write,
   input  logic                 ex_reg_write,
   input  logic [DATA_W-1:0]    ex_alu_result,
   input  logic [DATA_W-1:0]    ex_store_data,
   input  logic [REG_W-1:0]     ex_rt,
   input  logic                 flush,
   output logic                 ex_ready,
   output logic                 ls_req,
   output logic                 ls_we,
   output logic [LS_ADDR_W-1:0] ls_addr,
   output logic [DATA_W-1:0]    ls_wdata,
   input  logic                 ls_ack,
   input  logic [DATA_W-1:0]    ls_rdata,
   output logic                 wb_valid,
   output logic                 wb_reg_write,
   output logic [REG_W-1:0]     wb_rt,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 ls_timeout
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   // writeback context captured at accept and replayed on completion
   typedef struct packed {
      logic [REG_W-1:0] rt;
      logic             rw;
   } wb_ctx_t;

   logic [0:0]       state;
   logic [CNT_W-1:0] to_cnt;
   wb_ctx_t          ctx;
   logic             accept;
   logic             is_mem;
   logic             to_limit;

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid & ex_ready & ~flush;
   assign is_mem   = ex_mem_read | ex_mem_write;
   assign to_limit = (to_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         to_cnt       <= '0;
         ctx          <= '0;
         ls_req       <= 1'b0;
         ls_we        <= 1'b0;
         ls_addr      <= '0;
         ls_wdata     <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rt        <= '0;
         wb_data      <= '0;
         ls_timeout   <= 1'b0;
      end else begin
         wb_valid   <= 1'b0;
         ls_timeout <= 1'b0;
         if (state == IDLE) begin
            if (accept && is_mem) begin
               state    <= ACCESS;
               to_cnt   <= '0;
               ls_req   <= 1'b1;
               ls_we    <= ex_mem_write;
               ls_addr  <= ex_alu_result[LS_ADDR_W+3:4];
               ls_wdata <= ex_store_data;
               ctx.rt   <= ex_rt;
               // stores never write the register file, even if both mem bits are set
               ctx.rw   <= ex_reg_write & ~ex_mem_write;
            end else if (accept) begin
               wb_valid     <= 1'b1;
               wb_data      <= ex_alu_result;
               wb_rt        <= ex_rt;
               wb_reg_write <= ex_reg_write;
            end
         end else begin
            // ack wins over a timeout landing in the same cycle
            if (ls_ack) begin
               state        <= IDLE;
               ls_req       <= 1'b0;
               wb_valid     <= 1'b1;
               wb_rt        <= ctx.rt;
               wb_reg_write <= ls_we ? 1'b0 : ctx.rw;
               wb_data      <= ls_we ? '0 : ls_rdata;
            end else if (to_limit) begin
               state        <= IDLE;
               ls_req       <= 1'b0;
               ls_timeout   <= 1'b1;
               wb_valid     <= 1'b1;
               wb_rt        <= ctx.rt;
               wb_reg_write <= 1'b0;
               wb_data      <= '0;
            end else begin
               to_cnt <= to_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): passthrough, load/store, flush, timeout, reset.
module tb_mem_access_stage;
   localparam int DATA_W = 128, LS_ADDR_W = 14, REG_W = 7, TIMEOUT = 4;

   logic clk, reset;
   logic ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, flush, ex_ready;
   logic [DATA_W-1:0] ex_alu_result, ex_store_data, ls_wdata, ls_rdata, wb_data;
   logic [REG_W-1:0] ex_rt, wb_rt;
   logic ls_req, ls_we, ls_ack, wb_valid, wb_reg_write, ls_timeout;
   logic [LS_ADDR_W-1:0] ls_addr;

   int tests_run = 0, tests_failed = 0;

   localparam logic [DATA_W-1:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [DATA_W-1:0] CAFE = 128'hCAFEF00D_00000000_11112222_33334444;

   mem_access_stage #(.DATA_W(DATA_W), .LS_ADDR_W(LS_ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_rt(ex_rt), .flush(flush), .ex_ready(ex_ready),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack),
      .ls_rdata(ls_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rt(wb_rt),
      .wb_data(wb_data), .ls_timeout(ls_timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; flush = 0;
      ex_alu_result = '0; ex_store_data = '0; ex_rt = '0; ls_ack = 0; ls_rdata = '0;
   endtask

   task automatic start_load(input logic [DATA_W-1:0] addr, input logic [REG_W-1:0] rt);
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_alu_result = addr; ex_rt = rt;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1; idle_inputs();
      step(); step();
      tests_run++; if (ls_req !== 0) begin tests_failed++; $display("FAIL reset_ls_req got %b exp 0", ls_req); end
      tests_run++; if (ex_ready !== 1) begin tests_failed++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
      tests_run++; if ({wb_valid, wb_reg_write, wb_rt, wb_data, ls_timeout} !== '0) begin tests_failed++; $display("FAIL reset_wb got %b/%b/%h/%h/%b exp 0", wb_valid, wb_reg_write, wb_rt, wb_data, ls_timeout); end
      tests_run++; if ({ls_we, ls_addr, ls_wdata} !== '0) begin tests_failed++; $display("FAIL reset_ls got %b/%h/%h exp 0", ls_we, ls_addr, ls_wdata); end
      reset = 0;
      step();
   endtask

   task automatic test_passthrough();
      logic [DATA_W-1:0] v [3];
      v[0] = 128'h5A5A; v[1] = 128'h15A5A; v[2] = 128'h25A5A;
      for (int i = 0; i < 3; i++) begin
         ex_valid = 1; ex_reg_write = 1; ex_rt = 7'd3; ex_alu_result = v[i];
         step();
         tests_run++; if (wb_valid !== 1 || wb_rt !== 7'd3 || wb_reg_write !== 1 || wb_data !== v[i]) begin tests_failed++; $display("FAIL pass_%0d got v=%b rt=%0d rw=%b d=%h exp v=1 rt=3 rw=1 d=%h", i, wb_valid, wb_rt, wb_reg_write, wb_data, v[i]); end
      end
      idle_inputs();
      step();
      tests_run++; if (wb_valid !== 0 || wb_data !== v[2] || wb_rt !== 7'd3) begin tests_failed++; $display("FAIL pass_hold got v=%b d=%h rt=%0d exp v=0 d=%h rt=3", wb_valid, wb_data, wb_rt, v[2]); end
   endtask

   task automatic test_load_3cyc();
      start_load(128'h120, 7'd5);
      for (int c = 0; c < 3; c++) begin
         tests_run++; if (ls_req !== 1 || ex_ready !== 0 || ls_we !== 0 || ls_addr !== 14'h012 || wb_valid !== 0) begin tests_failed++; $display("FAIL load_wait_%0d got req=%b rdy=%b we=%b addr=%h wbv=%b exp req=1 rdy=0 we=0 addr=012 wbv=0", c, ls_req, ex_ready, ls_we, ls_addr, wb_valid); end
         if (c == 2) begin ls_ack = 1; ls_rdata = DEAD; end
         step();
      end
      idle_inputs();
      tests_run++; if (wb_valid !== 1 || wb_data !== DEAD || wb_rt !== 7'd5 || wb_reg_write !== 1 || ls_req !== 0 || ex_ready !== 1 || ls_timeout !== 0) begin tests_failed++; $display("FAIL load_done got v=%b d=%h rt=%0d rw=%b req=%b rdy=%b to=%b", wb_valid, wb_data, wb_rt, wb_reg_write, ls_req, ex_ready, ls_timeout); end
      step();
      tests_run++; if (wb_valid !== 0 || wb_data !== DEAD) begin tests_failed++; $display("FAIL load_pulse got v=%b d=%h exp v=0 d=%h", wb_valid, wb_data, DEAD); end
   endtask

   task automatic test_store_imm();
      // both mem bits set: store must win
      ex_valid = 1; ex_mem_write = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rt = 7'd9;
      ex_alu_result = 128'h4F; ex_store_data = 128'h1234;
      step();
      idle_inputs();
      tests_run++; if (ls_req !== 1 || ls_we !== 1 || ls_wdata !== 128'h1234 || ls_addr !== 14'h004) begin tests_failed++; $display("FAIL store_req got req=%b we=%b wd=%h addr=%h exp 1/1/1234/004", ls_req, ls_we, ls_wdata, ls_addr); end
      ls_ack = 1;
      step();
      ls_ack = 0;
      tests_run++; if (wb_valid !== 1 || wb_reg_write !== 0 || wb_data !== '0 || wb_rt !== 7'd9 || ls_req !== 0) begin tests_failed++; $display("FAIL store_done got v=%b rw=%b d=%h rt=%0d req=%b exp 1/0/0/9/0", wb_valid, wb_reg_write, wb_data, wb_rt, ls_req); end
      step();
   endtask

   task automatic test_flush();
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; flush = 1; ex_alu_result = 128'h300;
      step();
      idle_inputs();
      tests_run++; if (ls_req !== 0 || wb_valid !== 0 || ex_ready !== 1) begin tests_failed++; $display("FAIL flush_idle got req=%b wbv=%b rdy=%b exp 0/0/1", ls_req, wb_valid, ex_ready); end
      step();
      tests_run++; if (ls_req !== 0 || wb_valid !== 0) begin tests_failed++; $display("FAIL flush_idle2 got req=%b wbv=%b exp 0/0", ls_req, wb_valid); end
      start_load(128'h7770, 7'd11);
      flush = 1; ex_valid = 1;
      step();
      tests_run++; if (ls_req !== 1 || ls_addr !== 14'h0777) begin tests_failed++; $display("FAIL flush_access_hold got req=%b addr=%h exp 1/0777", ls_req, ls_addr); end
      ls_ack = 1; ls_rdata = CAFE;
      step();
      idle_inputs();
      tests_run++; if (wb_valid !== 1 || wb_data !== CAFE || wb_rt !== 7'd11 || wb_reg_write !== 1) begin tests_failed++; $display("FAIL flush_access_done got v=%b d=%h rt=%0d rw=%b", wb_valid, wb_data, wb_rt, wb_reg_write); end
      step();
   endtask

   task automatic test_timeout();
      start_load(128'h1000, 7'd2);
      for (int c = 0; c < TIMEOUT; c++) begin
         tests_run++; if (ls_req !== 1 || ls_timeout !== 0 || wb_valid !== 0) begin tests_failed++; $display("FAIL to_wait_%0d got req=%b to=%b wbv=%b exp 1/0/0", c, ls_req, ls_timeout, wb_valid); end
         step();
      end
      tests_run++; if (ls_req !== 0 || ls_timeout !== 1 || wb_valid !== 1 || wb_reg_write !== 0 || ex_ready !== 1) begin tests_failed++; $display("FAIL to_abort got req=%b to=%b v=%b rw=%b rdy=%b exp 0/1/1/0/1", ls_req, ls_timeout, wb_valid, wb_reg_write, ex_ready); end
      step();
      tests_run++; if (ls_timeout !== 0 || wb_valid !== 0) begin tests_failed++; $display("FAIL to_pulse got to=%b v=%b exp 0/0", ls_timeout, wb_valid); end
      // ack arriving on the limit cycle completes normally
      start_load(128'h2000, 7'd4);
      for (int c = 0; c < TIMEOUT; c++) begin
         if (c == TIMEOUT - 1) begin ls_ack = 1; ls_rdata = DEAD; end
         step();
      end
      idle_inputs();
      tests_run++; if (ls_timeout !== 0 || wb_valid !== 1 || wb_reg_write !== 1 || wb_data !== DEAD || wb_rt !== 7'd4 || ls_req !== 0) begin tests_failed++; $display("FAIL to_ack_limit got to=%b v=%b rw=%b d=%h rt=%0d req=%b", ls_timeout, wb_valid, wb_reg_write, wb_data, wb_rt, ls_req); end
      step();
   endtask

   task automatic test_reset_mid_access();
      start_load(128'h550, 7'd6);
      tests_run++; if (ls_req !== 1) begin tests_failed++; $display("FAIL rst_mid_pre got req=%b exp 1", ls_req); end
      #2 reset = 1;
      #1;
      tests_run++; if (ls_req !== 0 || ex_ready !== 1 || {wb_valid, wb_reg_write, wb_rt, wb_data, ls_timeout} !== '0) begin tests_failed++; $display("FAIL rst_mid got req=%b rdy=%b v=%b rw=%b rt=%0d d=%h to=%b", ls_req, ex_ready, wb_valid, wb_reg_write, wb_rt, wb_data, ls_timeout); end
      step();
      reset = 0;
      ls_ack = 1; ls_rdata = DEAD;
      for (int c = 0; c < 3; c++) begin
         step();
         tests_run++; if (wb_valid !== 0 || ls_req !== 0) begin tests_failed++; $display("FAIL rst_post_%0d got v=%b req=%b exp 0/0", c, wb_valid, ls_req); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_load_3cyc();
      test_store_imm();
      test_flush();
      test_timeout();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
